voice_demux8: RTL and testbench



---
 rtl/voice_demux8.sv | 162 ++++++++++++++++
 tb/tb_voice_demux8.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_demux8.sv
`default_nettype none
// ============================================================================
//  voice_demux8 : 8-voice note allocator / demultiplexer.
//  Holds the frequency word and gate of each voice and takes one
//  note-on/note-off command every 3 cycles.
//  Optional macro VOICE_STEAL_EN: when all voices are gated, a note-on steals
//  a voice round-robin instead of being dropped.
//  Revision: 1.0
// ============================================================================
module voice_demux8 #(
   parameter int WIDTH  = 20,
   parameter int NOTE_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_on,
   input  logic [NOTE_W-1:0] cmd_note,
   input  logic [WIDTH-1:0]  cmd_freq,
   output logic [WIDTH-1:0]  voice_a,
   output logic [WIDTH-1:0]  voice_b,
   output logic [WIDTH-1:0]  voice_c,
   output logic [WIDTH-1:0]  voice_d,
   output logic [WIDTH-1:0]  voice_e,
   output logic [WIDTH-1:0]  voice_f,
   output logic [WIDTH-1:0]  voice_g,
   output logic [WIDTH-1:0]  voice_h,
   output logic [7:0]        gate,
   output logic [2:0]        last_voice,
   output logic              dropped
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  freq_q [8];
   logic [NOTE_W-1:0] note_q [8];
   logic [7:0]        gate_q;
   logic [7:0]        match_q;
   logic [7:0]        free_q;
   logic [7:0]        match_d;
   logic [2:0]        last_q;
   logic              ready_q;
   logic              drop_q;
   logic              on_q;
   logic [NOTE_W-1:0] cmd_note_q;
   logic [WIDTH-1:0]  cmd_freq_q;
   logic [2:0]        hit_idx_d;
   logic [2:0]        free_idx_d;
`ifdef VOICE_STEAL_EN
   logic [2:0]        steal_ptr_q;
`endif

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (v[i]) idx = 3'(i);
      return idx;
   endfunction

   // Only COMMIT writes voice state, so vectors taken in SCAN stay valid.
   always_comb begin
      match_d = '0;
      for (int i = 0; i < 8; i++)
         match_d[i] = gate_q[i] && (note_q[i] == cmd_note_q);
   end

   assign hit_idx_d  = lowest_set(match_q);
   assign free_idx_d = lowest_set(free_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         drop_q     <= 1'b0;
         gate_q     <= '0;
         last_q     <= '0;
         match_q    <= '0;
         free_q     <= '0;
         on_q       <= 1'b0;
         cmd_note_q <= '0;
         cmd_freq_q <= '0;
         for (int i = 0; i < 8; i++) begin
            freq_q[i] <= '0;
            note_q[i] <= '0;
         end
`ifdef VOICE_STEAL_EN
         steal_ptr_q <= '0;
`endif
      end else begin
         drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  on_q       <= cmd_on;
                  cmd_note_q <= cmd_note;
                  cmd_freq_q <= cmd_freq;
                  ready_q    <= 1'b0;
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               match_q <= match_d;
               free_q  <= ~gate_q;
               state_q <= COMMIT;
            end
            COMMIT: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
               if (on_q) begin
                  if (|match_q) begin
                     freq_q[hit_idx_d] <= cmd_freq_q;
                     last_q            <= hit_idx_d;
                  end else if (|free_q) begin
                     freq_q[free_idx_d] <= cmd_freq_q;
                     note_q[free_idx_d] <= cmd_note_q;
                     gate_q[free_idx_d] <= 1'b1;
                     last_q             <= free_idx_d;
                  end else begin
`ifdef VOICE_STEAL_EN
                     freq_q[steal_ptr_q] <= cmd_freq_q;
                     note_q[steal_ptr_q] <= cmd_note_q;
                     gate_q[steal_ptr_q] <= 1'b1;
                     last_q              <= steal_ptr_q;
                     steal_ptr_q         <= steal_ptr_q + 3'd1;
`else
                     drop_q <= 1'b1;
`endif
                  end
               end else begin
                  gate_q <= gate_q & ~match_q;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = ready_q;
   assign gate       = gate_q;
   assign last_voice = last_q;
   assign dropped    = drop_q;
   assign voice_a    = freq_q[0];
   assign voice_b    = freq_q[1];
   assign voice_c    = freq_q[2];
   assign voice_d    = freq_q[3];
   assign voice_e    = freq_q[4];
   assign voice_f    = freq_q[5];
   assign voice_g    = freq_q[6];
   assign voice_h    = freq_q[7];

endmodule
`default_nettype wire

// File: tb/tb_voice_demux8.sv
`default_nettype none
// tb_voice_demux8 : randomized self-checking bench for voice_demux8 with an
// array-based allocation model; honours VOICE_STEAL_EN like the design.
module tb_voice_demux8;
   localparam int WIDTH  = 20;
   localparam int NOTE_W = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_on = 1'b0;
   logic [NOTE_W-1:0] cmd_note = '0;
   logic [WIDTH-1:0]  cmd_freq = '0;
   logic              cmd_ready;
   logic [WIDTH-1:0]  voice_a, voice_b, voice_c, voice_d;
   logic [WIDTH-1:0]  voice_e, voice_f, voice_g, voice_h;
   logic [7:0]        gate;
   logic [2:0]        last_voice;
   logic              dropped;

   voice_demux8 #(.WIDTH(WIDTH), .NOTE_W(NOTE_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_freq(cmd_freq),
      .voice_a(voice_a), .voice_b(voice_b), .voice_c(voice_c), .voice_d(voice_d),
      .voice_e(voice_e), .voice_f(voice_f), .voice_g(voice_g), .voice_h(voice_h),
      .gate(gate), .last_voice(last_voice), .dropped(dropped)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [WIDTH-1:0] dut_voice(input int i);
      case (i)
         0: return voice_a;
         1: return voice_b;
         2: return voice_c;
         3: return voice_d;
         4: return voice_e;
         5: return voice_f;
         6: return voice_g;
         default: return voice_h;
      endcase
   endfunction

   // Behavioural model: voices as plain arrays, a command takes effect
   // two edges after it is accepted.
   logic [WIDTH-1:0]  m_freq [8];
   logic [NOTE_W-1:0] m_note [8];
   bit                m_gate [8];
   int                m_last, m_steal, m_cnt, cyc, acc_cyc;
   bit                m_drop, m_acc;
   bit                l_on;
   logic [NOTE_W-1:0] l_note;
   logic [WIDTH-1:0]  l_freq;

   function automatic logic [7:0] gate_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_gate[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_freq[i] = '0;
         m_note[i] = '0;
         m_gate[i] = 1'b0;
      end
      m_last = 0; m_steal = 0; m_cnt = 0; m_drop = 1'b0; m_acc = 1'b0;
   endtask

   task automatic model_apply();
      int idx;
      idx = -1;
      if (l_on) begin
         for (int i = 0; i < 8; i++)
            if (idx < 0 && m_gate[i] && m_note[i] == l_note) idx = i;
         for (int i = 0; i < 8; i++)
            if (idx < 0 && !m_gate[i]) idx = i;
         if (idx < 0) begin
`ifdef VOICE_STEAL_EN
            idx = m_steal;
            m_steal = (m_steal + 1) % 8;
`else
            m_drop = 1'b1;
`endif
         end
         if (idx >= 0) begin
            m_freq[idx] = l_freq;
            m_note[idx] = l_note;
            m_gate[idx] = 1'b1;
            m_last = idx;
         end
      end else begin
         for (int i = 0; i < 8; i++)
            if (m_gate[i] && m_note[i] == l_note) m_gate[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      cyc++;
      m_acc = 1'b0;
      if (rst) return;
      m_drop = 1'b0;
      if (m_cnt == 0) begin
         if (cmd_valid) begin
            l_on = cmd_on; l_note = cmd_note; l_freq = cmd_freq;
            m_cnt = 2; m_acc = 1'b1; acc_cyc = cyc;
         end
      end else begin
         m_cnt--;
         if (m_cnt == 0) model_apply();
      end
   endtask

   always @(negedge clk) begin
      chk("ready",   32'(cmd_ready),  32'(m_cnt == 0));
      chk("gate",    32'(gate),       32'(gate_vec()));
      chk("last",    32'(last_voice), 32'(m_last));
      chk("dropped", 32'(dropped),    32'(m_drop));
      for (int i = 0; i < 8; i++)
         chk($sformatf("voice%0d", i), 32'(dut_voice(i)), 32'(m_freq[i]));
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic send(input bit on, input int note, input int freq, input bit hold);
      cmd_valid = 1'b1;
      cmd_on    = on;
      cmd_note  = NOTE_W'(note);
      cmd_freq  = WIDTH'(freq);
      m_acc     = 1'b0;
      for (int k = 0; k < 8 && !m_acc; k++) step();
      if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      @(negedge clk); #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_gate",  32'(gate),      32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h1);
      @(negedge clk); #2;
      rst = 1'b0;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int prev;
      model_reset();
      cyc = 0; acc_cyc = 0;
      do_reset();

      // First note-on: visible two cycles after accept, ready low for two cycles.
      send(1'b1, 60, 'h12345, 1'b0);
      chk("t1_ready_scan", 32'(cmd_ready), 32'h0);
      step();
      chk("t1_ready_commit", 32'(cmd_ready), 32'h0);
      step();
      chk("t1_ready_back", 32'(cmd_ready), 32'h1);
      chk("t1_voice_a", 32'(voice_a), 32'h12345);
      chk("t1_gate", 32'(gate), 32'h01);
      chk("t1_last", 32'(last_voice), 32'h0);

      // Fill all voices, release one, reuse it.
      do_reset();
      for (int n = 60; n < 68; n++) begin send(1'b1, n, n, 1'b0); idle(2); end
      chk("fill_gate", 32'(gate), 32'hFF);
      chk("fill_voice_h", 32'(voice_h), 32'd67);
      send(1'b0, 62, 0, 1'b0); idle(2);
      chk("off62_gate", 32'(gate), 32'hFB);
      chk("off62_voice_c", 32'(voice_c), 32'd62);
      send(1'b1, 70, 'h00ABC, 1'b0); idle(2);
      chk("n70_voice_c", 32'(voice_c), 32'h00ABC);
      chk("n70_last", 32'(last_voice), 32'h2);
      chk("n70_gate", 32'(gate), 32'hFF);

      // Retrigger and unmatched note-off.
      do_reset();
      send(1'b1, 60, 'h11111, 1'b0); idle(2);
      send(1'b1, 60, 'h22222, 1'b0); idle(2);
      chk("retrig_voice_a", 32'(voice_a), 32'h22222);
      chk("retrig_voice_b", 32'(voice_b), 32'h0);
      chk("retrig_gate", 32'(gate), 32'h01);
      send(1'b0, 99, 0, 1'b0); idle(2);
      chk("off99_gate", 32'(gate), 32'h01);
      chk("off99_voice_a", 32'(voice_a), 32'h22222);

      // Full: three extra note-ons.
      do_reset();
      for (int n = 60; n < 68; n++) begin send(1'b1, n, n, 1'b0); idle(2); end
      for (int k = 0; k < 3; k++) begin
         send(1'b1, 80 + k, 'hA + k, 1'b0);
         idle(2);
`ifdef VOICE_STEAL_EN
         chk("steal_drop", 32'(dropped), 32'h0);
         chk("steal_last", 32'(last_voice), 32'(k));
         chk("steal_voice", 32'(dut_voice(k)), 32'('hA + k));
`else
         chk("full_drop_pulse", 32'(dropped), 32'h1);
         chk("full_last", 32'(last_voice), 32'h7);
         chk("full_voice", 32'(dut_voice(k)), 32'(60 + k));
         idle(1);
         chk("full_drop_end", 32'(dropped), 32'h0);
`endif
      end

      // Reset during SCAN of a pending note-on.
      do_reset();
      send(1'b1, 61, 'h00777, 1'b0); idle(2);
      send(1'b1, 60, 'h55555, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_voice_a", 32'(voice_a), 32'h0);
      chk("midrst_gate", 32'(gate), 32'h0);
      chk("midrst_ready", 32'(cmd_ready), 32'h1);
      @(negedge clk); #2;
      rst = 1'b0;
      idle(3);
      chk("midrst_not_applied", 32'(gate), 32'h0);
      send(1'b1, 62, 'h00321, 1'b0); idle(2);
      chk("midrst_next_voice_a", 32'(voice_a), 32'h00321);
      chk("midrst_next_last", 32'(last_voice), 32'h0);

      // Back-to-back with cmd_valid held high: one accept every 3 cycles.
      do_reset();
      prev = 0;
      for (int i = 0; i < 24; i++) begin
         send(1'($urandom_range(0, 3) != 0), 60 + $urandom_range(0, 9),
              int'($urandom_range(0, 'hFFFFF)), 1'b1);
         if (i > 0) chk("b2b_interval", 32'(acc_cyc - prev), 32'd3);
         prev = acc_cyc;
      end
      idle(3);

      // Random traffic with gaps and garbage on idle inputs.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            cmd_on   = 1'($urandom);
            cmd_note = NOTE_W'($urandom);
            cmd_freq = WIDTH'($urandom);
            idle($urandom_range(1, 3));
         end
         send(1'($urandom_range(0, 9) < 6), 58 + $urandom_range(0, 11),
              int'($urandom_range(0, 'hFFFFF)), 1'($urandom));
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
